// File: rtl/reg_update_reader.sv
// reg_update_reader
//
// Read-side companion for an enable-written register. Snoops the writer's EN/D_IN strobe,
// keeps a registered copy of the last written value and tells a consumer that an update is
// waiting through an EMPTY_N/DEQ handshake. Updates overwritten before the consumer read
// them set the sticky OVF flag and are counted in a saturating DROP_CNT.
//
// Ports:
//   CLK      in   clock, all state updates on posedge
//   RST_N    in   asynchronous active-low reset
//   EN       in   write strobe of the snooped register
//   D_IN     in   value being written to the snooped register
//   DEQ      in   consumer acknowledges the current update
//   CLR      in   clears DROP_CNT
//   D_OUT    out  last captured value (registered)
//   EMPTY_N  out  an update is captured and not yet acknowledged
//   OVF      out  sticky: an unread update was overwritten since the last accepted DEQ
//   DROP_CNT out  saturating count of overwritten unread updates
module reg_update_reader #(
  parameter int unsigned            width = 1,
  parameter logic [width-1:0]       init  = '0,
  parameter int unsigned            cntw  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [width-1:0] D_IN,
  input  logic             DEQ,
  input  logic             CLR,
  output logic [width-1:0] D_OUT,
  output logic             EMPTY_N,
  output logic             OVF,
  output logic [cntw-1:0]  DROP_CNT
);

  typedef enum logic [0:0] {StIdle = 1'b0, StPending = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [width-1:0]  data_q, data_d;
  logic              ovf_q, ovf_d;
  logic [cntw-1:0]   cnt_q, cnt_d;
  logic              overwrite;

  // An overwrite is a new write landing on an update nobody has acknowledged yet.
  assign overwrite = (state_q == StPending) && EN && !DEQ;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;

    if (EN) begin
      data_d = D_IN;
    end

    unique case (state_q)
      StIdle: begin
        // DEQ with nothing pending is ignored.
        if (EN) begin
          state_d = StPending;
        end
      end
      StPending: begin
        if (DEQ) begin
          ovf_d = 1'b0;
          // EN together with DEQ consumes the old value and captures the new one.
          if (!EN) begin
            state_d = StIdle;
          end
        end else if (EN) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      // A drop in the same cycle as the clear must not be lost.
      cnt_d = overwrite ? cntw'(1) : '0;
    end else if (overwrite && (cnt_q != {cntw{1'b1}})) begin
      cnt_d = cnt_q + cntw'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      data_q  <= init;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign D_OUT    = data_q;
  assign EMPTY_N  = (state_q == StPending);
  assign OVF      = ovf_q;
  assign DROP_CNT = cnt_q;

endmodule

// File: tb/tb_reg_update_reader.sv
// Directed self-checking bench for reg_update_reader (width=8, init=8'hA5, cntw=4).
// Inputs are driven at the falling edge; outputs are sampled at the falling edge, packed as
// {D_OUT, EMPTY_N, OVF, DROP_CNT}.
module tb_reg_update_reader;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [7:0] D_IN;
  logic       DEQ;
  logic       CLR;
  logic [7:0] D_OUT;
  logic       EMPTY_N;
  logic       OVF;
  logic [3:0] DROP_CNT;

  int checks   = 0;
  int failures = 0;
  logic [13:0] obs;
  logic [13:0] exp_v;

  reg_update_reader #(
    .width(8),
    .init (8'hA5),
    .cntw (4)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .D_IN    (D_IN),
    .DEQ     (DEQ),
    .CLR     (CLR),
    .D_OUT   (D_OUT),
    .EMPTY_N (EMPTY_N),
    .OVF     (OVF),
    .DROP_CNT(DROP_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One clock with the given inputs; returns at the following falling edge with inputs idle.
  task automatic cyc(input logic en, input logic [7:0] d, input logic deq, input logic clr);
    EN   = en;
    D_IN = d;
    DEQ  = deq;
    CLR  = clr;
    @(negedge CLK);
    EN   = 1'b0;
    DEQ  = 1'b0;
    CLR  = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    EN = 1'b0; D_IN = 8'h00; DEQ = 1'b0; CLR = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'hA5, 1'b0, 1'b0, 4'd0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_held: got %h want %h", obs, exp_v);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'hA5, 1'b0, 1'b0, 4'd0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL reset_released: got %h want %h", obs, exp_v);
    end
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h3C, 1'b1, 1'b0, 4'd0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL first_capture: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_deq();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h3C, 1'b0, 1'b0, 4'd0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL deq_to_idle: got %h want %h", obs, exp_v);
    end
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h11, 1'b1, 1'b0, 4'd0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL capture_11: got %h want %h", obs, exp_v);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h11, 1'b0, 1'b0, 4'd0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL deq_holds_data: got %h want %h", obs, exp_v);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h11, 1'b0, 1'b0, 4'd0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL deq_in_idle: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
    end
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h05, 1'b1, 1'b1, 4'd4}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL back_to_back_5: got %h want %h", obs, exp_v);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h05, 1'b0, 1'b0, 4'd4}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL deq_clears_ovf: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_saturation_clr();
    // From IDLE with count 4: first EN captures, the next 10 add 10 drops.
    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    end
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h8A, 1'b1, 1'b1, 4'hE}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL count_14: got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    end
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h99, 1'b1, 1'b1, 4'hF}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL saturate: got %h want %h", obs, exp_v);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h99, 1'b1, 1'b1, 4'h0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL clr: got %h want %h", obs, exp_v);
    end
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h77, 1'b1, 1'b1, 4'h1}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL clr_with_overwrite: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_en_deq_same();
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h22, 1'b1, 1'b1, 4'h2}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL setup_22: got %h want %h", obs, exp_v);
    end
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h33, 1'b1, 1'b0, 4'h2}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL en_deq_same: got %h want %h", obs, exp_v);
    end
    // Equal value still counts as an update; with DEQ it is no drop, and CLR zeroes.
    cyc(1'b1, 8'h33, 1'b1, 1'b1);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h33, 1'b1, 1'b0, 4'h0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL clr_with_en_deq: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h55, 1'b1, 1'b1, 4'h1}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL setup_ovf: got %h want %h", obs, exp_v);
    end
    #2 RST_N = 1'b0;
    #1;
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'hA5, 1'b0, 1'b0, 4'h0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL async_reset: got %h want %h", obs, exp_v);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    obs = {D_OUT, EMPTY_N, OVF, DROP_CNT}; exp_v = {8'h66, 1'b1, 1'b0, 4'h0}; checks++;
    if (obs !== exp_v) begin
      failures++; $display("FAIL en_after_reset: got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    EN = 1'b0; D_IN = 8'h00; DEQ = 1'b0; CLR = 1'b0;
    @(negedge CLK);
    test_reset();
    test_deq();
    test_back_to_back();
    test_saturation_clr();
    test_en_deq_same();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_update_reader.md
# reg_update_reader

Read-side companion for a basic enable-written register. It snoops the writer's EN/D_IN strobe and keeps a registered copy of the last written value. It flags "unread update pending" to a consumer through an EMPTY_N/DEQ handshake and counts updates overwritten before the consumer read them. It sits beside any enable-written state register whose changes a slower agent (CSR poller, debug module, trace) must observe without missing notification of an update.

## Interface
- `width`, 1: data width of D_IN/D_OUT.
- `init`, all zeros: value of D_OUT after reset.
- `cntw`, 4: width of DROP_CNT; counter saturates at 2^cntw-1.
- `CLK`  input  1  clock; all state updates on posedge.
- `RST_N`  input  1  reset; asynchronous, active-low.
- `EN`  input  1  write strobe of the snooped register; D_IN is valid when high.
- `D_IN`  input  width  value being written to the snooped register.
- `DEQ`  input  1  consumer acknowledges the current update.
- `CLR`  input  1  clears DROP_CNT.
- `D_OUT`  output  width  last captured value, registered.
- `EMPTY_N`  output  1  high when an update is captured and not yet acknowledged.
- `OVF`  output  1  sticky; an unread update was overwritten since the last accepted DEQ.
- `DROP_CNT`  output  cntw  saturating count of overwritten unread updates.

## Operation
- Two states, encoded by EMPTY_N: IDLE (0) and PENDING (1).
- Reset (RST_N low, any time, asynchronous): D_OUT=init, EMPTY_N=0, OVF=0, DROP_CNT=0. Effect is immediate; there is no clock dependency. Outputs hold until the first posedge after RST_N rises.
- IDLE, EN=1: D_OUT<=D_IN; go to PENDING; OVF and DROP_CNT unchanged.
- IDLE, DEQ=1: DEQ is ignored; no state change and no error.
- PENDING, EN=0, DEQ=0: hold everything.
- PENDING, DEQ=1, EN=0: go to IDLE; OVF<=0; D_OUT holds its value.
- PENDING, EN=1, DEQ=0: latest wins. D_OUT<=D_IN; stay PENDING; OVF<=1; DROP_CNT increments and saturates at all ones.
- PENDING, EN=1, DEQ=1: the old value is consumed and the new value captured. D_OUT<=D_IN; stay PENDING; OVF<=0; DROP_CNT unchanged.
- CLR=1: DROP_CNT<=0, unless an overwrite occurs in the same cycle, in which case DROP_CNT<=1. CLR does not affect OVF, EMPTY_N or D_OUT.
- D_OUT changes only on EN or reset. A written value equal to the current D_OUT still counts as an update.
- No combinational path from any input to any output.

## Timing
- Capture latency is 1 cycle: EN/D_IN sampled at edge k appear on D_OUT, with EMPTY_N=1, after edge k.
- DEQ sampled at edge k drops EMPTY_N after edge k. The consumer must sample D_OUT in or before the cycle it asserts DEQ.
- OVF and DROP_CNT update at the same edge as the overwriting EN.
- Back-to-back EN every cycle with no DEQ: the first EN sets PENDING. Each subsequent EN is one overwrite, so N strobes give N-1 drops.
- Reset deassertion mid-operation resumes with IDLE state. Any EN in the first cycle after RST_N rises is captured normally.

## Test plan
- width=8, init=8'hA5, cntw=4. Hold reset, then release -> D_OUT=8'hA5, EMPTY_N=0, OVF=0, DROP_CNT=0. Then EN with D_IN=8'h3C -> next cycle D_OUT=8'h3C, EMPTY_N=1.
- EN with 8'h11, then DEQ one cycle later -> EMPTY_N=0 after the DEQ edge, D_OUT stays 8'h11. DEQ again while EMPTY_N=0 -> no change.
- EN on 5 consecutive cycles (8'h01..8'h05), no DEQ -> D_OUT=8'h05, EMPTY_N=1, OVF=1, DROP_CNT=4. A later DEQ gives OVF=0 and DROP_CNT=4.
- 20 overwrites without DEQ -> DROP_CNT saturates at 4'hF. CLR -> DROP_CNT=0. CLR together with an overwrite -> DROP_CNT=1.
- In PENDING with D_OUT=8'h22, EN (8'h33) and DEQ in the same cycle -> D_OUT=8'h33, EMPTY_N=1, OVF=0, DROP_CNT unchanged.
- Assert RST_N low asynchronously, between clock edges, while PENDING with OVF=1 -> outputs return to reset values immediately, before the next posedge.
